// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector MEM-stage responder and its control path.
// State codes are plain constants so legacy decoders can compare against them.
package vec_mem_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_LW    = 32;

  typedef logic [2:0] vm_state_t;

  localparam vm_state_t ST_IDLE  = 3'd0;
  localparam vm_state_t ST_WRITE = 3'd1;
  localparam vm_state_t ST_READ  = 3'd2;
  localparam vm_state_t ST_DRAIN = 3'd3;
  localparam vm_state_t ST_DONE  = 3'd4;

  // States in which the responder owns the RAM and must hold the pipeline.
  function automatic logic is_busy(input vm_state_t st);
    return (st == ST_WRITE) || (st == ST_READ) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/vec_word_ram.sv
// Synchronous single-port word RAM: one-cycle read latency, write-first.
module vec_word_ram #(
  parameter int AW = 10,
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] wdata,
  output logic [LW-1:0] rdata
);

  logic [LW-1:0] mem_r [0:(1<<AW)-1];

  // Storage array and registered read port; a write forwards its own data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
      rdata       <= wdata;
    end else begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/vec_mem_responder.sv
// Serialises one vector load/store into LANES single-word RAM cycles and
// holds the pipeline with stall until the access completes.
module vec_mem_responder
  import vec_mem_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int LW    = DEF_LW,
  parameter int AW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wmem,
  input  logic                rmem,
  input  logic [AW-1:0]       addr,
  input  logic [LANES*LW-1:0] wdata,
  output logic                stall,
  output logic                done,
  output logic [LANES*LW-1:0] rdata,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_we,
  output logic [LW-1:0]       ram_wdata,
  input  logic [LW-1:0]       ram_rdata
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LANE_ZERO = CW'(0);
  localparam logic [CW-1:0] LANE_ONE  = CW'(1);
  localparam logic [CW-1:0] LANE_LAST = CW'(LANES - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  vm_state_t           state_r;
  logic [CW-1:0]       lane_r;
  logic [LANES*LW-1:0] wbuf_r;
  logic [LANES*LW-1:0] rbuf_r;
  logic [LANES*LW-1:0] rbuf_next_s;
  logic                done_r;
  logic                ram_we_r;
  logic [AW-1:0]       ram_addr_r;
  logic [LW-1:0]       ram_wdata_r;
  logic [LANES*LW-1:0] rdata_r;
  logic                stall_s;

  // Read words arrive in lane order and are shifted in from the top, so
  // after LANES captures lane 0 sits in the least significant slot.
  always_comb begin
    rbuf_next_s = {ram_rdata, rbuf_r[LANES*LW-1:LW]};
  end

  // Hold the pipeline while a request is pending in IDLE or an access is underway.
  always_comb begin
    if (state_r == ST_IDLE) begin
      stall_s = wmem | rmem;
    end else begin
      stall_s = is_busy(state_r);
    end
  end

  // Access sequencer: lane counter, RAM port registers and read assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lane_r      <= LANE_ZERO;
      wbuf_r      <= '0;
      rbuf_r      <= '0;
      done_r      <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      rdata_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wmem) begin
            state_r     <= ST_WRITE;
            lane_r      <= LANE_ZERO;
            ram_we_r    <= 1'b1;
            ram_addr_r  <= addr;
            ram_wdata_r <= wdata[LW-1:0];
            wbuf_r      <= wdata >> LW;
          end else if (rmem) begin
            state_r    <= ST_READ;
            lane_r     <= LANE_ZERO;
            ram_we_r   <= 1'b0;
            ram_addr_r <= addr;
            rbuf_r     <= '0;
          end else begin
            state_r  <= ST_IDLE;
            ram_we_r <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (lane_r == LANE_LAST) begin
            state_r  <= ST_DONE;
            lane_r   <= LANE_ZERO;
            ram_we_r <= 1'b0;
            done_r   <= 1'b1;
          end else begin
            lane_r      <= lane_r + LANE_ONE;
            ram_addr_r  <= ram_addr_r + ADDR_ONE;
            ram_wdata_r <= wbuf_r[LW-1:0];
            wbuf_r      <= wbuf_r >> LW;
          end
        end
        ST_READ: begin
          // The word on ram_rdata belongs to the previous lane's address.
          if (lane_r != LANE_ZERO) begin
            rbuf_r <= rbuf_next_s;
          end else begin
            rbuf_r <= rbuf_r;
          end
          if (lane_r == LANE_LAST) begin
            state_r <= ST_DRAIN;
            lane_r  <= LANE_ZERO;
          end else begin
            lane_r     <= lane_r + LANE_ONE;
            ram_addr_r <= ram_addr_r + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          state_r  <= ST_DONE;
          ram_we_r <= 1'b0;
          rdata_r  <= rbuf_next_s;
          done_r   <= 1'b1;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          lane_r   <= LANE_ZERO;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = stall_s;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign ram_addr  = ram_addr_r;
  assign ram_we    = ram_we_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Self-checking bench for vec_mem_responder against a word-addressed memory
// model, with directed corner cases followed by randomized traffic.
module tb_vec_mem_responder;

  localparam int LANES = 4;
  localparam int LW    = 32;
  localparam int AW    = 10;

  logic                clk;
  logic                rst;
  logic                wmem;
  logic                rmem;
  logic [AW-1:0]       addr;
  logic [LANES*LW-1:0] wdata;
  logic                stall;
  logic                done;
  logic [LANES*LW-1:0] rdata;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;
  logic [LW-1:0]       ram_wdata;
  logic [LW-1:0]       ram_rdata;

  vec_mem_responder #(.LANES(LANES), .LW(LW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wmem(wmem), .rmem(rmem), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  vec_word_ram #(.AW(AW), .LW(LW)) ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: memory contents by word address and the expected rdata.
  logic [LW-1:0]       mem_m [int];
  logic [LANES*LW-1:0] rdata_m;
  logic [AW-1:0]       bases [$];
  int tests = 0;
  int fails = 0;
  int we_seen = 0;
  int we_exp = 0;

  always @(negedge clk) begin
    if (ram_we === 1'b1) we_seen++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [LANES*LW-1:0] gather(input logic [AW-1:0] a);
    logic [LANES*LW-1:0] v;
    int wa;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      wa = (int'(a) + i) % (1 << AW);
      v[i*LW +: LW] = mem_m.exists(wa) ? mem_m[wa] : '0;
    end
    return v;
  endfunction

  // One request presented in an IDLE cycle; every following cycle is checked
  // against the expected store (LANES+1 cycles) or load (LANES+2 cycles) timeline.
  task automatic access(input bit wr, input bit rd, input logic [AW-1:0] a,
                        input logic [LANES*LW-1:0] wd);
    logic [LANES*LW-1:0] exp_rd;
    logic [AW-1:0] la;
    int last;
    int k;
    @(negedge clk);
    wmem = wr; rmem = rd; addr = a; wdata = wd;
    #1;
    check("stall_req", stall, 1'b1);
    check("we_idle", ram_we, 1'b0);
    exp_rd = gather(a);
    last = wr ? LANES + 1 : LANES + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      k = (c - 1 > LANES - 1) ? LANES - 1 : c - 1;
      la = a + AW'(k);
      check("ram_addr", ram_addr, la);
      check("ram_we", ram_we, wr && (c <= LANES));
      if (wr) check("ram_wdata", ram_wdata, wd[k*LW +: LW]);
      check("stall", stall, c != last);
      check("done", done, c == last);
      if (c == last) check("rdata", rdata, wr ? rdata_m : exp_rd);
    end
    wmem = 1'b0; rmem = 1'b0;
    if (wr) begin
      for (int i = 0; i < LANES; i++) mem_m[(int'(a) + i) % (1 << AW)] = wd[i*LW +: LW];
      we_exp += LANES;
      bases.push_back(a);
    end else begin
      rdata_m = exp_rd;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_we"}, ram_we, 1'b0);
    check({tag, "_addr"}, ram_addr, '0);
    check({tag, "_wdata"}, ram_wdata, '0);
    check({tag, "_rdata"}, rdata, '0);
  endtask

  initial begin
    logic [LANES*LW-1:0] v;
    logic [AW-1:0] b;
    int op;
    rst = 1'b1; wmem = 1'b0; rmem = 1'b0; addr = '0; wdata = '0;
    rdata_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed: plain store/load, wrap at top of memory, simultaneous strobes.
    access(1'b1, 1'b0, 10'h010, 128'h44444444_33333333_22222222_11111111);
    access(1'b0, 1'b1, 10'h010, '0);
    access(1'b1, 1'b0, 10'h3FE, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    check("wrap_lo", mem_m.exists(0) ? 1'b1 : 1'b0, 1'b1);
    access(1'b0, 1'b1, 10'h3FE, '0);
    access(1'b1, 1'b1, 10'h020, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0);
    access(1'b0, 1'b1, 10'h020, '0);

    // Asynchronous reset in the middle of a load, then the same load again.
    @(negedge clk);
    rmem = 1'b1; addr = 10'h010;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1; rmem = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rdata_m = '0;
    @(negedge clk);
    rst = 1'b0;
    check("post_reset_rdata", rdata, '0);
    access(1'b0, 1'b1, 10'h010, '0);

    // Back-to-back store then load on the minimum one-IDLE-cycle spacing.
    access(1'b1, 1'b0, 10'h155, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF);
    access(1'b0, 1'b1, 10'h155, '0);

    // Randomized mix of stores, loads and dual-strobe requests.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      v = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = AW'(10'h3FC + AW'($urandom_range(0, 3)));
      else b = AW'($urandom);
      if (op == 1) begin
        b = bases[$urandom_range(0, bases.size() - 1)];
        access(1'b0, 1'b1, b, '0);
      end else begin
        access(1'b1, op == 2, b, v);
      end
    end

    @(negedge clk);
    check("we_count", we_seen, we_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
